// File: rtl/sys_bus_pkg.sv
// Shared constants for the CPU-side system bridge and its interrupt controller.
package sys_bus_pkg;

    // Maximum number of devices and interrupt channels
    localparam int MAX_DEV = 6;

    // Default address map
    localparam logic [31:0] DEF_DEV_BASE = 32'h0000_7F00;
    localparam logic [31:0] DEF_IC_BASE  = 32'h0000_7F80;

    // Interrupt controller register word offsets (praddr[3:2])
    localparam logic [1:0] IC_PEND = 2'd0;
    localparam logic [1:0] IC_MASK = 2'd1;
    localparam logic [1:0] IC_ACK  = 2'd2;
    localparam logic [1:0] IC_MODE = 2'd3;

endpackage

// File: rtl/irq_ctrl.sv
// Interrupt controller: per-channel edge/level pending capture, mask, ack and
// registered hwint output.
module irq_ctrl
    import sys_bus_pkg::*;
#(
    parameter int         N_DEV     = 2,
    parameter logic [5:0] EDGE_MODE = 6'b000000,
    parameter logic [5:0] MASK_RST  = 6'b111111
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_DEV-1:0] dev_irq,
    input  logic             wr_en,
    input  logic [1:0]       wr_off,
    input  logic [5:0]       wr_data,
    output logic [5:0]       pend,
    output logic [5:0]       mask,
    output logic [5:0]       hwint
);

    logic [5:0] irq_w;
    logic [5:0] irq_q;
    logic [5:0] pend_nxt;
    logic [5:0] ack;
    logic       armed;

    // ACK strobe: one-cycle write-1-to-clear vector
    assign ack = (wr_en && wr_off == IC_ACK) ? wr_data : 6'h00;

    // Per-channel next-pending; channels beyond N_DEV stay tied to 0
    for (genvar gi = 0; gi < MAX_DEV; gi++) begin : g_ch
        if (gi < N_DEV) begin : g_live
            assign irq_w[gi] = dev_irq[gi];
            if (EDGE_MODE[gi]) begin : g_edge
                // Set wins over simultaneous ack; no edges are seen until
                // irq_q has sampled the line once after reset.
                assign pend_nxt[gi] = (armed & irq_w[gi] & ~irq_q[gi]) |
                                      (pend[gi] & ~ack[gi]);
            end else begin : g_level
                assign pend_nxt[gi] = irq_w[gi];
            end
        end else begin : g_dead
            assign irq_w[gi]    = 1'b0;
            assign pend_nxt[gi] = 1'b0;
        end
    end

    // Pending, mask, delayed irq and hwint state
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q <= 6'h00;
            armed <= 1'b0;
            pend  <= 6'h00;
            mask  <= MASK_RST;
            hwint <= 6'h00;
        end else begin
            irq_q <= irq_w;
            armed <= 1'b1;
            pend  <= pend_nxt;
            if (wr_en && wr_off == IC_MASK)
                mask <= wr_data;
            hwint <= pend & mask;
        end
    end

endmodule

// File: rtl/sys_bridge_ic.sv
// System bridge: decodes CPU accesses onto N_DEV 16-byte device windows plus
// the interrupt controller window, muxes read data and flags unmapped accesses.
module sys_bridge_ic
    import sys_bus_pkg::*;
#(
    parameter int          N_DEV     = 2,
    parameter logic [31:0] DEV_BASE  = DEF_DEV_BASE,
    parameter logic [31:0] IC_BASE   = DEF_IC_BASE,
    parameter logic [5:0]  EDGE_MODE = 6'b000000,
    parameter logic [5:0]  MASK_RST  = 6'b111111
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          praddr,
    input  logic [31:0]          prwd,
    input  logic                 prwe,
    input  logic [3:0]           prbe,
    output logic [31:0]          prrd,
    output logic                 prerr,
    output logic [1:0]           devaddr,
    output logic [31:0]          devwd,
    output logic [3:0]           devbe,
    output logic [N_DEV-1:0]     dev_we,
    input  logic [32*N_DEV-1:0]  dev_rd,
    input  logic [N_DEV-1:0]     dev_irq,
    output logic [5:0]           hwint
);

    logic [N_DEV-1:0]       sel_dev;
    logic [N_DEV-1:0][31:0] dev_rd_sel;
    logic [31:0]            dev_mux;
    logic                   sel_ic;
    logic                   ic_we;
    logic [5:0]             pend;
    logic [5:0]             mask;
    logic                   unused_addr;

    assign unused_addr = ^praddr[1:0];

    // Device pass-through
    assign devaddr = praddr[3:2];
    assign devwd   = prwd;
    assign devbe   = prbe;

    // Per-device window decode, write strobe and gated read data
    for (genvar gi = 0; gi < N_DEV; gi++) begin : g_dev
        localparam logic [31:0] WIN = DEV_BASE + 32'(16 * gi);
        assign sel_dev[gi]    = (praddr[31:4] == WIN[31:4]);
        assign dev_we[gi]     = prwe & sel_dev[gi];
        assign dev_rd_sel[gi] = sel_dev[gi] ? dev_rd[32*gi +: 32] : 32'h0;
    end

    assign sel_ic = (praddr[31:4] == IC_BASE[31:4]);
    assign prerr  = ~(|sel_dev | sel_ic);

    // Controller writes only on full-word access
    assign ic_we = prwe & sel_ic & (prbe == 4'hF);

    // Same-cycle read mux; windows are disjoint so OR-combining is safe
    always_comb begin
        dev_mux = 32'h0;
        for (int i = 0; i < N_DEV; i++)
            dev_mux = dev_mux | dev_rd_sel[i];
        prrd = 32'h0;
        if (|sel_dev) begin
            prrd = dev_mux;
        end else if (sel_ic) begin
            case (praddr[3:2])
                IC_PEND: prrd = {26'h0, pend};
                IC_MASK: prrd = {26'h0, mask};
                IC_ACK:  prrd = 32'h0;
                default: prrd = {26'h0, EDGE_MODE};
            endcase
        end
    end

    irq_ctrl #(
        .N_DEV     (N_DEV),
        .EDGE_MODE (EDGE_MODE),
        .MASK_RST  (MASK_RST)
    ) u_irq (
        .clk     (clk),
        .reset   (reset),
        .dev_irq (dev_irq),
        .wr_en   (ic_we),
        .wr_off  (praddr[3:2]),
        .wr_data (prwd[5:0]),
        .pend    (pend),
        .mask    (mask),
        .hwint   (hwint)
    );

endmodule

// File: tb/tb_sys_bridge_ic.sv
// Directed bench for sys_bridge_ic: decode, read mux, controller registers,
// edge/level pending, mask, ack and reset behaviour.
module tb_sys_bridge_ic;
    import sys_bus_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] praddr;
    logic [31:0] prwd;
    logic        prwe;
    logic [3:0]  prbe;
    logic [31:0] prrd;
    logic        prerr;
    logic [1:0]  devaddr;
    logic [31:0] devwd;
    logic [3:0]  devbe;
    logic [1:0]  dev_we;
    logic [63:0] dev_rd;
    logic [1:0]  dev_irq;
    logic [5:0]  hwint;

    int errors = 0;
    int checks = 0;

    sys_bridge_ic #(
        .N_DEV     (2),
        .EDGE_MODE (6'b000001),
        .MASK_RST  (6'b111111)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .praddr  (praddr),
        .prwd    (prwd),
        .prwe    (prwe),
        .prbe    (prbe),
        .prrd    (prrd),
        .prerr   (prerr),
        .devaddr (devaddr),
        .devwd   (devwd),
        .devbe   (devbe),
        .dev_we  (dev_we),
        .dev_rd  (dev_rd),
        .dev_irq (dev_irq),
        .hwint   (hwint)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Combinational read of a register/window with no write
    task automatic rd(input logic [31:0] a);
        praddr = a;
        prwe   = 1'b0;
        #1;
    endtask

    // One-cycle write, then drop prwe
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        praddr = a;
        prwd   = d;
        prbe   = be;
        prwe   = 1'b1;
        step();
        prwe   = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        praddr  = 32'h0;
        prwd    = 32'h0;
        prwe    = 1'b0;
        prbe    = 4'hF;
        dev_rd  = 64'h0;
        dev_irq = 2'b00;
        step();
        step();
        reset = 1'b0;

        // Reset state
        chk("rst_hwint", {26'h0, hwint}, 32'h0);
        rd(32'h7F80); chk("rst_pend", prrd, 32'h0);
        rd(32'h7F84); chk("rst_mask", prrd, 32'h3F);
        rd(32'h7F8C); chk("mode", prrd, 32'h1);
        rd(32'h7F88); chk("ack_rd0", prrd, 32'h0);

        // Device write decode
        praddr = 32'h7F14; prwd = 32'hA5; prbe = 4'hF; prwe = 1'b1;
        #1;
        chk("wr_dev_we", {30'h0, dev_we}, 32'h2);
        chk("wr_devaddr", {30'h0, devaddr}, 32'h1);
        chk("wr_devwd", devwd, 32'hA5);
        chk("wr_prerr", {31'h0, prerr}, 32'h0);
        prwe = 1'b0;

        // Device read mux
        dev_rd = {32'h5678_0000, 32'h0000_1234};
        rd(32'h7F04);
        chk("rd_dev0", prrd, 32'h1234);
        chk("rd_dev0_err", {31'h0, prerr}, 32'h0);
        chk("rd_dev0_we", {30'h0, dev_we}, 32'h0);
        rd(32'h7F1C); chk("rd_dev1", prrd, 32'h5678_0000);

        // Unmapped accesses
        praddr = 32'h7F40; prwd = 32'h0; prwe = 1'b1; prbe = 4'hF;
        #1;
        chk("unm_err", {31'h0, prerr}, 32'h1);
        chk("unm_rd", prrd, 32'h0);
        chk("unm_we", {30'h0, dev_we}, 32'h0);
        step();
        prwe = 1'b0;
        rd(32'h7F20); chk("unm_20_err", {31'h0, prerr}, 32'h1);
        rd(32'h7F90); chk("unm_90_err", {31'h0, prerr}, 32'h1);
        rd(32'h7F84); chk("unm_mask", prrd, 32'h3F);

        // Partial-byte MASK write is ignored
        wr(32'h7F84, 32'h0, 4'h1);
        rd(32'h7F84); chk("part_mask", prrd, 32'h3F);
        prbe = 4'hF;

        // Edge channel 0: one-cycle pulse
        dev_irq = 2'b01;
        step();
        dev_irq = 2'b00;
        rd(32'h7F80); chk("edge_pend", prrd, 32'h1);
        chk("edge_hw_k1", {26'h0, hwint}, 32'h0);
        step();
        chk("edge_hw_k2", {26'h0, hwint}, 32'h1);
        wr(32'h7F88, 32'h1, 4'hF);
        chk("ack_hw_k1", {26'h0, hwint}, 32'h1);
        rd(32'h7F80); chk("ack_pend", prrd, 32'h0);
        step();
        chk("ack_hw_k2", {26'h0, hwint}, 32'h0);

        // Ack coinciding with a new rising edge: set wins
        dev_irq = 2'b01;
        step();
        dev_irq = 2'b00;
        step();
        dev_irq = 2'b01;
        wr(32'h7F88, 32'h1, 4'hF);
        rd(32'h7F80); chk("ack_race", prrd, 32'h1);
        dev_irq = 2'b00;
        wr(32'h7F88, 32'h1, 4'hF);
        rd(32'h7F80); chk("ack_clr", prrd, 32'h0);

        // Level channel 1, mask and ineffective ack
        dev_irq = 2'b10;
        step();
        rd(32'h7F80); chk("lvl_pend", prrd, 32'h2);
        step();
        chk("lvl_hw", {26'h0, hwint}, 32'h2);
        wr(32'h7F84, 32'h3D, 4'hF);
        chk("mask_hw_k", {26'h0, hwint}, 32'h2);
        step();
        chk("mask_hw_k1", {26'h0, hwint}, 32'h0);
        wr(32'h7F88, 32'h2, 4'hF);
        rd(32'h7F80); chk("lvl_ack", prrd, 32'h2);

        // Mid-run reset with PEND=3, MASK=0
        dev_irq = 2'b11;
        step();
        dev_irq = 2'b10;
        wr(32'h7F84, 32'h0, 4'hF);
        rd(32'h7F80); chk("pre_rst_pend", prrd, 32'h3);
        rd(32'h7F84); chk("pre_rst_mask", prrd, 32'h0);
        dev_irq = 2'b11;
        reset = 1'b1;
        step();
        reset = 1'b0;
        rd(32'h7F80); chk("mid_rst_pend", prrd, 32'h0);
        rd(32'h7F84); chk("mid_rst_mask", prrd, 32'h3F);
        chk("mid_rst_hw", {26'h0, hwint}, 32'h0);

        // dev_irq[0] held high across reset must not register an edge
        step();
        step();
        rd(32'h7F80); chk("rst_edge_sup", prrd, 32'h2);
        step();
        chk("post_rst_hw", {26'h0, hwint}, 32'h2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
